// File: rtl/sprite_sched.sv
// sprite_sched: four-slot bouncing sprite position scheduler.
// Ports: pixel_clk/rst, raster hcnt/vcnt, active hsize/vsize,
//   cfg_* host write (valid/ready), spr_x/spr_y/spr_color/spr_en
//   packed per-slot state, busy during a sweep, frame_tick at sweep end.
module sprite_sched #(
    parameter int unsigned FRAME_DIV = 1
) (
    input  logic        pixel_clk,
    input  logic        rst,
    input  logic [11:0] hcnt,
    input  logic [11:0] vcnt,
    input  logic [11:0] hsize,
    input  logic [11:0] vsize,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [1:0]  cfg_slot,
    input  logic [11:0] cfg_x,
    input  logic [11:0] cfg_y,
    input  logic [3:0]  cfg_step,
    input  logic        cfg_en,
    output logic [47:0] spr_x,
    output logic [47:0] spr_y,
    output logic [11:0] spr_color,
    output logic [3:0]  spr_en,
    output logic        busy,
    output logic        frame_tick
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        COMMIT,
        DONE
    } state_t;

    typedef struct packed {
        logic [11:0] pos;
        logic        dir;
        logic        bounce;
    } axis_t;

    localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);

    // One axis step. 13-bit compare keeps pos+step from wrapping
    // before it is tested against the far edge.
    function automatic axis_t axis_step(
        input logic [11:0] pos,
        input logic        dir,
        input logic [3:0]  step,
        input logic [11:0] size
    );
        axis_t       r;
        logic [12:0] sum;
        logic [12:0] lim;
        sum      = {1'b0, pos} + {9'd0, step};
        lim      = {1'b0, size} - 13'd1;
        r.pos    = pos;
        r.dir    = dir;
        r.bounce = 1'b0;
        if (dir) begin
            if (sum >= lim) begin
                r.pos    = size - 12'd1;
                r.dir    = 1'b0;
                r.bounce = 1'b1;
            end else begin
                r.pos = sum[11:0];
            end
        end else begin
            if ({1'b0, pos} <= {9'd0, step}) begin
                r.pos    = 12'd0;
                r.dir    = 1'b1;
                r.bounce = 1'b1;
            end else begin
                r.pos = pos - {8'd0, step};
            end
        end
        return r;
    endfunction

    // Colour cycles 1..7, never 0.
    function automatic logic [2:0] color_next(input logic [2:0] c);
        return (c == 3'd7) ? 3'd1 : c + 3'd1;
    endfunction

    state_t      state_q;
    state_t      state_d;
    logic [1:0]  slot_q;
    logic [1:0]  slot_d;
    logic [7:0]  frame_cnt;
    logic        frame_start;
    logic        trigger;
    logic        cfg_accept;
    logic        calc_load;
    logic        commit;
    logic        busy_q;
    logic        tick_q;

    logic [11:0] pos_x [4];
    logic [11:0] pos_y [4];
    logic [3:0]  step_q [4];
    logic [2:0]  color_q [4];
    logic [3:0]  en_q;
    logic [3:0]  dir_x_q;
    logic [3:0]  dir_y_q;

    axis_t       calc_x;
    axis_t       calc_y;
    axis_t       nx;
    axis_t       ny;
    logic [2:0]  calc_color;

    logic [11:0] hmax;
    logic [11:0] vmax;
    logic [11:0] load_x;
    logic [11:0] load_y;

    assign frame_start = (vcnt == vsize) && (hcnt == 12'd0);
    assign trigger     = frame_start && (frame_cnt == DIV_LAST);
    assign cfg_ready   = (state_q == IDLE) && !trigger;
    assign cfg_accept  = cfg_valid && cfg_ready;
    assign calc_load   = (state_q == CALC);
    assign commit      = (state_q == COMMIT);

    assign hmax   = hsize - 12'd1;
    assign vmax   = vsize - 12'd1;
    assign load_x = (cfg_x > hmax) ? hmax : cfg_x;
    assign load_y = (cfg_y > vmax) ? vmax : cfg_y;

    // Frame divider. A wrap that lands mid-sweep is simply dropped;
    // the sweep is far shorter than a frame.
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= 8'd0;
        end else if (frame_start) begin
            frame_cnt <= (frame_cnt == DIV_LAST) ? 8'd0 : frame_cnt + 8'd1;
        end
    end

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            slot_q  <= 2'd0;
            busy_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            busy_q  <= (state_d == CALC) || (state_d == COMMIT);
            tick_q  <= (state_d == DONE);
        end
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        unique case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d = CALC;
                    slot_d  = 2'd0;
                end
            end
            CALC: begin
                state_d = COMMIT;
            end
            COMMIT: begin
                if (slot_q == 2'd3) begin
                    state_d = DONE;
                end else begin
                    state_d = CALC;
                    slot_d  = slot_q + 2'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign nx = axis_step(pos_x[slot_q], dir_x_q[slot_q],
                          step_q[slot_q], hsize);
    assign ny = axis_step(pos_y[slot_q], dir_y_q[slot_q],
                          step_q[slot_q], vsize);

    // CALC registers the slot's next state; COMMIT writes it back.
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            calc_x     <= '0;
            calc_y     <= '0;
            calc_color <= 3'd1;
        end else if (calc_load) begin
            calc_x     <= nx;
            calc_y     <= ny;
            calc_color <= (nx.bounce || ny.bounce)
                        ? color_next(color_q[slot_q])
                        : color_q[slot_q];
        end
    end

    // Host writes only land in IDLE, so they never meet a COMMIT.
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                pos_x[i]   <= 12'd0;
                pos_y[i]   <= 12'd0;
                step_q[i]  <= 4'd0;
                color_q[i] <= 3'd1;
            end
            en_q    <= 4'd0;
            dir_x_q <= 4'hf;
            dir_y_q <= 4'hf;
        end else if (cfg_accept) begin
            pos_x[cfg_slot]   <= load_x;
            pos_y[cfg_slot]   <= load_y;
            step_q[cfg_slot]  <= cfg_step;
            color_q[cfg_slot] <= 3'd1;
            en_q[cfg_slot]    <= cfg_en;
            dir_x_q[cfg_slot] <= 1'b1;
            dir_y_q[cfg_slot] <= 1'b1;
        end else if (commit && en_q[slot_q]) begin
            pos_x[slot_q]   <= calc_x.pos;
            pos_y[slot_q]   <= calc_y.pos;
            dir_x_q[slot_q] <= calc_x.dir;
            dir_y_q[slot_q] <= calc_y.dir;
            color_q[slot_q] <= calc_color;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_pack
        assign spr_x[12*i +: 12]   = pos_x[i];
        assign spr_y[12*i +: 12]   = pos_y[i];
        assign spr_color[3*i +: 3] = color_q[i];
    end

    assign spr_en     = en_q;
    assign busy       = busy_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_sprite_sched.sv
// tb_sprite_sched: directed bench for sprite_sched.
// Vector table for single sweeps plus hand sequences for corner cases.
module tb_sprite_sched;

    logic        pixel_clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] hcnt = 12'd1;
    logic [11:0] vcnt = 12'd0;
    logic [11:0] hsize = 12'd640;
    logic [11:0] vsize = 12'd480;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_slot = 2'd0;
    logic [11:0] cfg_x = 12'd0;
    logic [11:0] cfg_y = 12'd0;
    logic [3:0]  cfg_step = 4'd0;
    logic        cfg_en = 1'b0;
    logic [47:0] spr_x;
    logic [47:0] spr_y;
    logic [11:0] spr_color;
    logic [3:0]  spr_en;
    logic        busy;
    logic        frame_tick;

    logic        d3_cfg_ready;
    logic [47:0] d3_spr_x;
    logic [47:0] d3_spr_y;
    logic [11:0] d3_spr_color;
    logic [3:0]  d3_spr_en;
    logic        d3_busy;
    logic        d3_frame_tick;

    int n_checks = 0;
    int n_fail = 0;

    always #5 pixel_clk = ~pixel_clk;

    sprite_sched #(.FRAME_DIV(1)) u_dut (
        .pixel_clk (pixel_clk),
        .rst       (rst),
        .hcnt      (hcnt),
        .vcnt      (vcnt),
        .hsize     (hsize),
        .vsize     (vsize),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_slot  (cfg_slot),
        .cfg_x     (cfg_x),
        .cfg_y     (cfg_y),
        .cfg_step  (cfg_step),
        .cfg_en    (cfg_en),
        .spr_x     (spr_x),
        .spr_y     (spr_y),
        .spr_color (spr_color),
        .spr_en    (spr_en),
        .busy      (busy),
        .frame_tick(frame_tick)
    );

    sprite_sched #(.FRAME_DIV(3)) u_div3 (
        .pixel_clk (pixel_clk),
        .rst       (rst),
        .hcnt      (hcnt),
        .vcnt      (vcnt),
        .hsize     (hsize),
        .vsize     (vsize),
        .cfg_valid (1'b0),
        .cfg_ready (d3_cfg_ready),
        .cfg_slot  (2'd0),
        .cfg_x     (12'd0),
        .cfg_y     (12'd0),
        .cfg_step  (4'd0),
        .cfg_en    (1'b0),
        .spr_x     (d3_spr_x),
        .spr_y     (d3_spr_y),
        .spr_color (d3_spr_color),
        .spr_en    (d3_spr_en),
        .busy      (d3_busy),
        .frame_tick(d3_frame_tick)
    );

    typedef struct {
        logic [1:0]  slot;
        logic [11:0] x;
        logic [11:0] y;
        logic [3:0]  step;
        logic        en;
        logic [11:0] ex;
        logic [11:0] ey;
        logic [2:0]  ecol;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [47:0] act,
                         input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic apply_reset(input logic [11:0] h, input logic [11:0] v);
        rst       = 1'b1;
        cfg_valid = 1'b0;
        hcnt      = 12'd1;
        vcnt      = 12'd0;
        hsize     = h;
        vsize     = v;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic cfg_write(input logic [1:0] s, input logic [11:0] x,
                             input logic [11:0] y, input logic [3:0] st,
                             input logic en);
        int n;
        n         = 0;
        cfg_valid = 1'b1;
        cfg_slot  = s;
        cfg_x     = x;
        cfg_y     = y;
        cfg_step  = st;
        cfg_en    = en;
        #1;
        while (!cfg_ready && n < 40) begin
            tick();
            n++;
        end
        if (!cfg_ready) check("cfg_ready_wait", cfg_ready, 1);
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic frame_pulse();
        vcnt = vsize;
        hcnt = 12'd0;
        tick();
        vcnt = 12'd0;
        hcnt = 12'd1;
    endtask

    task automatic run_sweep(output int busy_cnt, output int tick_at);
        busy_cnt = 0;
        tick_at  = 0;
        frame_pulse();
        for (int c = 1; c <= 20; c++) begin
            if (busy) busy_cnt++;
            if (frame_tick && tick_at == 0) tick_at = c;
            tick();
            if (tick_at != 0) break;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        int ta;
        int cnt;
        int win;
        logic [4:0] started;
        logic [3:0] exp_en;

        vecs[0] = '{2'd0, 12'd100, 12'd50,  4'd2, 1'b1, 12'd102, 12'd52,  3'd1};
        vecs[1] = '{2'd1, 12'd637, 12'd10,  4'd4, 1'b1, 12'd639, 12'd14,  3'd2};
        vecs[2] = '{2'd3, 12'd700, 12'd479, 4'd3, 1'b1, 12'd639, 12'd479, 3'd2};
        vecs[3] = '{2'd2, 12'd100, 12'd100, 4'd5, 1'b0, 12'd100, 12'd100, 3'd1};
        vecs[4] = '{2'd0, 12'd639, 12'd200, 4'd0, 1'b1, 12'd639, 12'd200, 3'd2};
        vecs[5] = '{2'd3, 12'd300, 12'd478, 4'd1, 1'b1, 12'd301, 12'd479, 3'd2};
        vecs[6] = '{2'd1, 12'd0,   12'd0,   4'd7, 1'b1, 12'd7,   12'd7,   3'd1};

        // reset state
        apply_reset(12'd640, 12'd480);
        check("rst_busy", busy, 0);
        check("rst_tick", frame_tick, 0);
        check("rst_x", spr_x, 0);
        check("rst_y", spr_y, 0);
        check("rst_en", spr_en, 0);
        check("rst_color", spr_color, 12'h249);
        check("rst_ready", cfg_ready, 1);

        // single-sweep vectors
        for (int i = 0; i < 7; i++) begin
            apply_reset(12'd640, 12'd480);
            cfg_write(vecs[i].slot, vecs[i].x, vecs[i].y,
                      vecs[i].step, vecs[i].en);
            run_sweep(bc, ta);
            exp_en = vecs[i].en ? (4'b0001 << vecs[i].slot) : 4'd0;
            check($sformatf("v%0d_busy_len", i), bc, 8);
            check($sformatf("v%0d_tick_at", i), ta, 9);
            check($sformatf("v%0d_tick_end", i), frame_tick, 0);
            check($sformatf("v%0d_x", i),
                  spr_x[12*vecs[i].slot +: 12], vecs[i].ex);
            check($sformatf("v%0d_y", i),
                  spr_y[12*vecs[i].slot +: 12], vecs[i].ey);
            check($sformatf("v%0d_col", i),
                  spr_color[3*vecs[i].slot +: 3], vecs[i].ecol);
            check($sformatf("v%0d_en", i), spr_en, exp_en);
        end

        // right-edge bounce then reverse travel
        apply_reset(12'd640, 12'd480);
        cfg_write(2'd1, 12'd637, 12'd10, 4'd4, 1'b1);
        run_sweep(bc, ta);
        check("edge_x1", spr_x[23:12], 12'd639);
        check("edge_col1", spr_color[5:3], 3'd2);
        run_sweep(bc, ta);
        check("edge_x2", spr_x[23:12], 12'd635);
        check("edge_y2", spr_y[23:12], 12'd18);
        check("edge_col2", spr_color[5:3], 3'd2);

        // corner bounce at origin on both axes, small frame
        apply_reset(12'd9, 12'd9);
        cfg_write(2'd2, 12'd8, 12'd8, 4'd5, 1'b1);
        run_sweep(bc, ta);
        check("org_x1", spr_x[35:24], 12'd8);
        check("org_col1", spr_color[8:6], 3'd2);
        run_sweep(bc, ta);
        check("org_x2", spr_x[35:24], 12'd3);
        check("org_y2", spr_y[35:24], 12'd3);
        run_sweep(bc, ta);
        check("org_x3", spr_x[35:24], 12'd0);
        check("org_y3", spr_y[35:24], 12'd0);
        check("org_col3", spr_color[8:6], 3'd3);
        run_sweep(bc, ta);
        check("org_x4", spr_x[35:24], 12'd5);
        check("org_y4", spr_y[35:24], 12'd5);
        check("org_col4", spr_color[8:6], 3'd3);

        // write colliding with a frame start
        apply_reset(12'd640, 12'd480);
        cfg_valid = 1'b1;
        cfg_slot  = 2'd0;
        cfg_x     = 12'd10;
        cfg_y     = 12'd20;
        cfg_step  = 4'd1;
        cfg_en    = 1'b1;
        vcnt      = vsize;
        hcnt      = 12'd0;
        #1;
        check("col_ready_trig", cfg_ready, 0);
        tick();
        vcnt = 12'd0;
        hcnt = 12'd1;
        cnt  = 0;
        for (int c = 1; c <= 9; c++) begin
            if (cfg_ready) cnt++;
            if (c < 9) tick();
        end
        check("col_ready_sweep", cnt, 0);
        check("col_tick", frame_tick, 1);
        check("col_x_pending", spr_x[11:0], 12'd0);
        tick();
        check("col_ready_idle", cfg_ready, 1);
        check("col_en_pending", spr_en, 4'd0);
        tick();
        cfg_valid = 1'b0;
        check("col_x", spr_x[11:0], 12'd10);
        check("col_y", spr_y[11:0], 12'd20);
        check("col_en", spr_en, 4'd1);

        // frame divider of 3
        apply_reset(12'd640, 12'd480);
        started = '0;
        cnt     = 0;
        win     = 0;
        for (int k = 1; k <= 5; k++) begin
            frame_pulse();
            started[k-1] = d3_busy;
            for (int c = 0; c < 12; c++) begin
                if (d3_frame_tick) begin
                    cnt++;
                    win = k;
                end
                tick();
            end
        end
        check("div3_start", started, 5'b00100);
        check("div3_ticks", cnt, 1);
        check("div3_window", win, 3);

        // reset mid-sweep during slot 1 commit
        apply_reset(12'd640, 12'd480);
        cfg_write(2'd0, 12'd100, 12'd50, 4'd2, 1'b1);
        cfg_write(2'd1, 12'd200, 12'd60, 4'd3, 1'b1);
        frame_pulse();
        tick();
        tick();
        tick();
        check("mid_busy_pre", busy, 1);
        check("mid_x0_pre", spr_x[11:0], 12'd102);
        rst = 1'b1;
        #1;
        check("mid_busy", busy, 0);
        check("mid_tick", frame_tick, 0);
        check("mid_x", spr_x, 0);
        check("mid_y", spr_y, 0);
        check("mid_en", spr_en, 0);
        check("mid_color", spr_color, 12'h249);
        tick();
        tick();
        rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (busy || frame_tick) cnt++;
        end
        check("mid_quiet", cnt, 0);
        check("mid_x_after", spr_x, 0);
        check("mid_ready_after", cfg_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
